// File: rtl/lii_pkg.sv
// Shared definitions for the LII output path: id width, arbiter FSM states and
// the round-robin selector used to pick the next requester.
package lii_pkg;

  localparam int LII_ID_W = 8;
  localparam int RR_MAX_N = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } lii_state_e;

  // First set bit of valid at or after ptr, wrapping modulo n; returns ptr if none.
  function automatic logic [3:0] rr_select(input logic [RR_MAX_N-1:0] valid,
                                           input logic [3:0]          ptr,
                                           input int                  n);
    logic [3:0] pick;
    logic [3:0] idx;
    logic       found;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < RR_MAX_N; i++) begin
      idx = 4'((int'(ptr) + i) % n);
      if (i < n && !found && valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/lii_reg_slice.sv
// Single-entry valid/ready pipeline register; full throughput when the sink is
// ready, payload held stable while stalled.
module lii_reg_slice #(
  parameter int W = 8
) (
  input  logic         aclk,
  input  logic         arst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  input  logic         i_ready
);

  logic         r_valid;
  logic [W-1:0] r_data;
  logic         w_load;

  assign o_ready = !r_valid || i_ready;
  assign w_load  = i_valid && o_ready;

  // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
  // NOTE: the payload is reset as well as valid, so the outputs read all-zero during reset.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/lii_out_arbiter.sv
// Round-robin burst arbiter merging N requester streams onto one LII output,
// tagging each beat with its source and destination ids.
module lii_out_arbiter
  import lii_pkg::*;
#(
  parameter int N        = 4,
  parameter int PW       = 64,
  parameter int MAXBURST = 16,
  parameter int SRC_BASE = 0
) (
  input  logic                  aclk,
  input  logic                  arst,
  input  logic [N*PW-1:0]       req_tdata,
  input  logic [N-1:0]          req_tvalid,
  output logic [N-1:0]          req_tready,
  input  logic [N*LII_ID_W-1:0] req_dst,
  output logic [PW-1:0]         lii_out_p0_tdata,
  output logic                  lii_out_p0_tvalid,
  input  logic                  lii_out_p0_tready,
  output logic [LII_ID_W-1:0]   lii_out_p0_src,
  output logic [LII_ID_W-1:0]   lii_out_p0_dst,
  output logic [$clog2(N)-1:0]  grant_idx,
  output logic                  busy
);

  localparam int GW = $clog2(N);
  localparam int CW = $clog2(MAXBURST + 1);
  localparam int OW = PW + 2 * LII_ID_W;

  lii_state_e          r_state;
  lii_state_e          w_next_state;
  logic [GW-1:0]       r_grant;
  logic [GW-1:0]       r_rr_ptr;
  logic [CW-1:0]       r_beat_cnt;
  logic [GW-1:0]       w_pick;
  logic [GW-1:0]       w_next_ptr;
  logic                w_busy;
  logic                w_any_valid;
  logic                w_g_valid;
  logic                w_slice_ready;
  logic                w_accept;
  logic                w_last_beat;
  logic                w_release;
  logic [PW-1:0]       w_g_data;
  logic [LII_ID_W-1:0] w_g_src;
  logic [LII_ID_W-1:0] w_g_dst;
  logic [OW-1:0]       w_out_payload;

  assign w_busy      = (r_state == ST_GRANT);
  assign w_any_valid = |req_tvalid;
  assign w_pick      = GW'(rr_select(16'(req_tvalid), 4'(r_rr_ptr), N));
  assign w_next_ptr  = (r_grant == GW'(N - 1)) ? '0 : r_grant + 1'b1;
  assign w_g_valid   = req_tvalid[r_grant];
  assign w_g_data    = req_tdata[r_grant*PW +: PW];
  assign w_g_dst     = req_dst[r_grant*LII_ID_W +: LII_ID_W];
  assign w_g_src     = LII_ID_W'(SRC_BASE + int'(r_grant));
  assign w_accept    = w_busy && w_g_valid && w_slice_ready;
  assign w_last_beat = (r_beat_cnt == CW'(MAXBURST - 1));
  // Release on a full burst, or when the granted stream stalls while it could send.
  assign w_release   = w_busy && ((w_accept && w_last_beat) || (!w_g_valid && w_slice_ready));

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) r_state <= ST_IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_any_valid) w_next_state = ST_GRANT;
      ST_GRANT: if (w_release)   w_next_state = ST_IDLE;
      default:                   w_next_state = ST_IDLE;
    endcase
  end

  // NOTE: every output gets a default before the conditional, so no latch is inferred.
  always_comb begin
    req_tready = '0;
    busy       = w_busy;
    grant_idx  = w_busy ? r_grant : '0;
    if (w_busy) req_tready[r_grant] = w_slice_ready;
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      if (r_state == ST_IDLE && w_any_valid) begin
        r_grant    <= w_pick;
        r_beat_cnt <= '0;
      end
      if (w_release) begin
        r_rr_ptr   <= w_next_ptr;
        r_beat_cnt <= '0;
      end else if (w_accept) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
    end
  end

  lii_reg_slice #(.W(OW)) u_out_slice (
    .aclk    (aclk),
    .arst    (arst),
    .i_valid (w_busy && w_g_valid),
    .o_ready (w_slice_ready),
    .i_data  ({w_g_dst, w_g_src, w_g_data}),
    .o_valid (lii_out_p0_tvalid),
    .o_data  (w_out_payload),
    .i_ready (lii_out_p0_tready)
  );

  assign {lii_out_p0_dst, lii_out_p0_src, lii_out_p0_tdata} = w_out_payload;

endmodule

// File: doc/lii_out_arbiter.md
LII_OUT_ARBITER -- requirements
Module: lii_out_arbiter

Interface
REQ-001 SHALL have parameter N, default 4: number of logical requester streams (2..16).
REQ-002 SHALL have parameter PW, default 64: LII packing width.
REQ-003 SHALL have parameter MAXBURST, default 16: maximum beats per grant (1..256).
REQ-004 SHALL have parameter SRC_BASE, default 0: LII source id of requester 0.
REQ-005 SHALL have port aclk  input  1  sole clock; all state changes on rising edge.
REQ-006 SHALL have port arst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port req_tdata  input  N*PW  requester data; slice i is requester i.
REQ-008 SHALL have port req_tvalid  input  N  per-requester valid.
REQ-009 SHALL have port req_tready  output  N  per-requester ready.
REQ-010 SHALL have port req_dst  input  N*8  per-requester LII destination id.
REQ-011 SHALL have port lii_out_p0_tdata  output  PW  merged phy data.
REQ-012 SHALL have port lii_out_p0_tvalid  output  1  phy valid.
REQ-013 SHALL have port lii_out_p0_tready  input  1  phy ready.
REQ-014 SHALL have port lii_out_p0_src  output  8  SRC_BASE plus the granted requester index.
REQ-015 SHALL have port lii_out_p0_dst  output  8  req_dst of the granted requester.
REQ-016 SHALL have port grant_idx  output  clog2(N)  current grant index; 0 when idle.
REQ-017 SHALL have port busy  output  1  high while in GRANT state.

Function
REQ-018 SHALL implement a two-state FSM: IDLE and GRANT.
REQ-019 In IDLE with any req_tvalid high, SHALL register grant to the first valid index at or after rr_ptr (wrapping modulo N) and enter GRANT next cycle.
REQ-020 In IDLE, SHALL drive all req_tready low.
REQ-021 In GRANT, req_tready[g] SHALL equal (!out_valid | lii_out_p0_tready); all other req_tready SHALL be 0.
REQ-022 A beat SHALL be accepted when req_tvalid[g] and req_tready[g] are both high. On acceptance, the output register SHALL load tdata slice g, src = SRC_BASE+g and dst = req_dst slice g, and set out_valid.
REQ-023 SHALL drive lii_out_p0_* from the output register; latency from IDLE tvalid to phy tvalid is 2 cycles.
REQ-024 While lii_out_p0_tvalid is high and lii_out_p0_tready is low, data, src and dst SHALL hold stable.
REQ-025 out_valid SHALL clear when the phy accepts the beat and no new beat is accepted in the same cycle.
REQ-026 A simultaneous phy accept and requester accept SHALL give full throughput: one beat per cycle.
REQ-027 beat_cnt SHALL count beats accepted in the current grant and reset to 0 on every release.
REQ-028 In GRANT, SHALL release to IDLE when the accepted beat makes beat_cnt reach MAXBURST, or when req_tvalid[g] is low in a cycle with req_tready[g] high.
REQ-029 On release, SHALL set rr_ptr = (g+1) mod N.
REQ-030 Release SHALL NOT discard the output register; a pending beat drains in IDLE.
REQ-031 Re-arbitration SHALL occur on the cycle after release; no requester SHALL win twice in a row while another is valid.
REQ-032 src and dst SHALL never mix between requesters within a beat.

Reset
REQ-033 When arst is asserted: state=IDLE, rr_ptr=0, beat_cnt=0, out_valid=0, lii_out_p0_tdata/src/dst=0, req_tready=0, grant_idx=0, busy=0.
REQ-034 Reset mid-burst SHALL drop any in-flight beat and clear the grant; operation resumes from IDLE with rr_ptr=0 on the first edge after arst deasserts.

Structure
REQ-035 SHALL place the LII id width (8), the FSM state enum, and the rr-select function in the shared lii_pkg package.
REQ-036 SHALL implement the output register as sub-module lii_reg_slice, which is reusable on the input side.

Verification
REQ-037 Directed test: req0 valid with 3 beats 0xA1..0xA3, dst=5, tready=1 -> phy tvalid 2 cycles later; beats in order; src=0, dst=5; then IDLE.
REQ-038 Directed test: all 4 requesters continuously valid, MAXBURST=16 -> grants 0,1,2,3,0 with 16 beats each and no idle cycles between beats within a grant.
REQ-039 Directed test: req2 streaming, phy tready low for 5 cycles -> output held stable, req_tready[2]=0, no beat lost or duplicated.
REQ-040 Directed test: req1 drops tvalid after 4 beats while req3 is valid -> release, rr_ptr=2, req3 granted, req3 beats have src=3.
REQ-041 Directed test: arst pulse mid-burst on req0 -> all outputs 0 within the same cycle; after deassert, req0 re-granted from beat_cnt=0.
REQ-042 Directed test: MAXBURST=1 with 2 requesters valid -> beats alternate 0,1,0,1.
